// File: rtl/beat_address_sequencer.sv
// beat_address_sequencer
//   Record/playback address generator for the beat memory. In record mode
//   each key change produces one RAM write at the next slot and extends the
//   recorded length; in playback mode the recorded slots are stepped through
//   at a rate of one slot every TICK_DIV clock cycles.
//
//   Optional feature macro: PLAYBACK_LOOP_EN
//     defined   : playback wraps to slot 0 at end of data, done pulses per wrap
//     undefined : playback stops in HALT at the last slot with done held high
module beat_address_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int KEY_W    = 7,
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              do_start,
    input  logic              mode,
    input  logic [KEY_W-1:0]  ascii,
    output logic [ADDR_W-1:0] address_out,
    output logic [KEY_W-1:0]  key_out,
    output logic              wr_en,
    output logic              tick,
    output logic [ADDR_W:0]   rec_len,
    output logic              busy,
    output logic              done,
    output logic              full
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [KEY_W-1:0]    prev_key_q, prev_key_d;
    logic                wr_en_q, wr_en_d;
    logic                tick_q, tick_d;
    logic [ADDR_W:0]     rec_len_q, rec_len_d;
    logic                done_q, done_d;
    logic                full_q, full_d;
    logic [DIV_W-1:0]    div_q, div_d;

    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W:0]     next_slot;

    assign addr_inc  = addr_q + 1'b1;
    assign next_slot = {1'b0, addr_q} + 1'b1;

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        key_d      = key_q;
        prev_key_d = prev_key_q;
        wr_en_d    = 1'b0;
        tick_d     = 1'b0;
        rec_len_d  = rec_len_q;
        done_d     = 1'b0;
        full_d     = full_q;
        div_d      = div_q;

        // A write strobe that is ending always counts toward the length,
        // even if the run is being aborted on this same edge.
        if (wr_en_q) begin
            rec_len_d = rec_len_q + 1'b1;
        end

        if (!do_start) begin
            state_d = S_IDLE;
            addr_d  = '0;
            full_d  = 1'b0;
            div_d   = DIV_RELOAD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d = '0;
                    if (!mode) begin
                        state_d    = S_RECORD;
                        prev_key_d = ascii;
                        rec_len_d  = '0;
                        full_d     = 1'b0;
                    end else if (rec_len_q == '0) begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PLAY;
                        div_d   = DIV_RELOAD;
                    end
                end

                S_RECORD: begin
                    // Advance past the slot just written, or saturate at the top.
                    if (wr_en_q) begin
                        if (addr_q == ADDR_MAX) begin
                            full_d = 1'b1;
                        end else begin
                            addr_d = addr_inc;
                        end
                    end
                    // full_d is used so a change arriving on the edge that
                    // fills the memory is already ignored.
                    if ((ascii != prev_key_q) && !full_d) begin
                        prev_key_d = ascii;
                        key_d      = ascii;
                        wr_en_d    = 1'b1;
                    end
                end

                S_PLAY: begin
                    if (div_q == '0) begin
                        div_d = DIV_RELOAD;
                        if (next_slot < rec_len_q) begin
                            addr_d = addr_inc;
                            tick_d = 1'b1;
                        end else begin
`ifdef PLAYBACK_LOOP_EN
                            addr_d = '0;
                            tick_d = 1'b1;
                            done_d = 1'b1;
`else
                            state_d = S_HALT;
                            done_d  = 1'b1;
`endif
                        end
                    end else begin
                        div_d = div_q - 1'b1;
                    end
                end

                S_HALT: begin
                    done_d = 1'b1;
                end

                default: begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            key_q      <= '0;
            prev_key_q <= '0;
            wr_en_q    <= 1'b0;
            tick_q     <= 1'b0;
            rec_len_q  <= '0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            div_q      <= DIV_RELOAD;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            key_q      <= key_d;
            prev_key_q <= prev_key_d;
            wr_en_q    <= wr_en_d;
            tick_q     <= tick_d;
            rec_len_q  <= rec_len_d;
            done_q     <= done_d;
            full_q     <= full_d;
            div_q      <= div_d;
        end
    end

    assign address_out = addr_q;
    assign key_out     = key_q;
    assign wr_en       = wr_en_q;
    assign tick        = tick_q;
    assign rec_len     = rec_len_q;
    assign done        = done_q;
    assign full        = full_q;
    assign busy        = (state_q == S_RECORD) || (state_q == S_PLAY);

endmodule

// File: tb/tb_beat_address_sequencer.sv
// Directed bench for beat_address_sequencer: small memory (4 slots) and a
// 4-cycle playback divider so record, fill, playback and halt all fit in a
// short run.
module tb_beat_address_sequencer;

    localparam int ADDR_W   = 2;
    localparam int KEY_W    = 7;
    localparam int TICK_DIV = 4;
    localparam int DIV_W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              do_start;
    logic              mode;
    logic [KEY_W-1:0]  ascii;
    logic [ADDR_W-1:0] address_out;
    logic [KEY_W-1:0]  key_out;
    logic              wr_en;
    logic              tick;
    logic [ADDR_W:0]   rec_len;
    logic              busy;
    logic              done;
    logic              full;

    int n_chk  = 0;
    int n_pass = 0;

    beat_address_sequencer #(
        .ADDR_W  (ADDR_W),
        .KEY_W   (KEY_W),
        .TICK_DIV(TICK_DIV),
        .DIV_W   (DIV_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .do_start   (do_start),
        .mode       (mode),
        .ascii      (ascii),
        .address_out(address_out),
        .key_out    (key_out),
        .wr_en      (wr_en),
        .tick       (tick),
        .rec_len    (rec_len),
        .busy       (busy),
        .done       (done),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Control flags packed as {wr_en, tick, busy, done, full}.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, wr_en, tick, busy, done, full}, {27'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        do_start = 1'b0;
        mode     = 1'b0;
        ascii    = '0;
        cyc();
        cyc();

        // Reset state
        check("rst_addr",    address_out, 0);
        check("rst_key",     key_out, 0);
        check("rst_reclen",  rec_len, 0);
        check_ctl("rst_ctl", 5'b00000);
        reset = 1'b0;
        cyc();
        check_ctl("idle_ctl", 5'b00000);

        // T1: keys 41,42,42,43 -> two writes at 0 and 1
        ascii = 7'h41; mode = 1'b0; do_start = 1'b1;
        cyc();
        check_ctl("t1_entry", 5'b00100);
        mode  = 1'b1;                 // ignored while busy
        ascii = 7'h42;
        cyc();
        check_ctl("t1_wr0_ctl", 5'b10100);
        check("t1_wr0_addr", address_out, 0);
        check("t1_wr0_key",  key_out, 7'h42);
        ascii = 7'h42;
        cyc();
        check_ctl("t1_same_ctl", 5'b00100);
        check("t1_same_addr", address_out, 1);
        check("t1_len1",      rec_len, 1);
        ascii = 7'h43;
        cyc();
        check_ctl("t1_wr1_ctl", 5'b10100);
        check("t1_wr1_addr", address_out, 1);
        check("t1_wr1_key",  key_out, 7'h43);
        cyc();
        check_ctl("t1_hold_ctl", 5'b00100);
        check("t1_len2",     rec_len, 2);
        do_start = 1'b0;
        cyc();
        check_ctl("t1_exit_ctl", 5'b00000);
        check("t1_exit_addr", address_out, 0);
        check("t1_keep_len",  rec_len, 2);

        // T2: back-to-back changes fill the 4-slot memory, 5th ignored
        mode = 1'b0; ascii = 7'h10; do_start = 1'b1;
        cyc();
        check("t2_len0", rec_len, 0);
        for (int i = 1; i <= 4; i++) begin
            ascii = 7'(7'h10 + i);
            cyc();
            check_ctl($sformatf("t2_wr%0d_ctl", i), 5'b10100);
            check($sformatf("t2_wr%0d_addr", i), address_out, i - 1);
            check($sformatf("t2_wr%0d_key", i),  key_out, 7'h10 + i);
        end
        ascii = 7'h15;
        cyc();
        check_ctl("t2_full_ctl", 5'b00101);
        check("t2_full_addr", address_out, 3);
        check("t2_len4",      rec_len, 4);
        ascii = 7'h16;
        cyc();
        check_ctl("t2_ign_ctl", 5'b00101);
        check("t2_ign_key",   key_out, 7'h14);
        check("t2_ign_len",   rec_len, 4);
        do_start = 1'b0;
        cyc();
        check_ctl("t2_exit_ctl", 5'b00000);

        // Record three slots for the playback tests
        mode = 1'b0; ascii = 7'h20; do_start = 1'b1;
        cyc();
        for (int i = 1; i <= 3; i++) begin
            ascii = 7'(7'h20 + i);
            cyc();
        end
        cyc();
        check("rec3_len", rec_len, 3);
        do_start = 1'b0;
        cyc();

        // T3/T4: playback, one step every 4 cycles
        mode = 1'b1; do_start = 1'b1;
        cyc();
        check_ctl("t3_entry_ctl", 5'b00100);
        check("t3_entry_addr", address_out, 0);
        for (int s = 1; s <= 2; s++) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                check($sformatf("t3_wait%0d_%0d", s, k), {tick, address_out}, {1'b0, 2'(s - 1)});
            end
            cyc();
            check_ctl($sformatf("t3_tick%0d_ctl", s), 5'b01100);
            check($sformatf("t3_tick%0d_addr", s), address_out, s);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("t3_wait3_%0d", k), {tick, address_out}, {1'b0, 2'd2});
        end
        cyc();
`ifdef PLAYBACK_LOOP_EN
        check_ctl("t4_wrap_ctl", 5'b01110);
        check("t4_wrap_addr", address_out, 0);
        cyc();
        check_ctl("t4_after_ctl", 5'b00100);
        check("t4_after_addr", address_out, 0);
        for (int k = 0; k < 2; k++) cyc();
        cyc();
        check_ctl("t4_step_ctl", 5'b01100);
        check("t4_step_addr", address_out, 1);
        for (int k = 0; k < 3; k++) cyc();
        cyc();
        check("t4_addr2", address_out, 2);
`else
        check_ctl("t3_halt_ctl", 5'b00010);
        check("t3_halt_addr", address_out, 2);
        cyc();
        cyc();
        check_ctl("t3_halt_hold", 5'b00010);
        check("t3_halt_addr2", address_out, 2);
        do_start = 1'b0;
        cyc();
        check_ctl("t3_exit_ctl", 5'b00000);
        check("t3_exit_addr", address_out, 0);
        mode = 1'b1; do_start = 1'b1;
        cyc();
        for (int k = 0; k < 8; k++) cyc();
        check("t5_pre_addr", address_out, 2);
`endif

        // T5: reset in the middle of playback at slot 2
        check("t5_busy", busy, 1);
        reset = 1'b1;
        cyc();
        check("t5_addr",   address_out, 0);
        check("t5_reclen", rec_len, 0);
        check("t5_key",    key_out, 0);
        check_ctl("t5_ctl", 5'b00000);
        reset = 1'b0;
        do_start = 1'b0;
        cyc();

        // T6: playback with nothing recorded
        mode = 1'b1; do_start = 1'b1;
        cyc();
        check_ctl("t6_halt_ctl", 5'b00010);
        for (int k = 0; k < 5; k++) cyc();
        check_ctl("t6_hold_ctl", 5'b00010);
        check("t6_addr", address_out, 0);
        do_start = 1'b0;
        cyc();
        check_ctl("t6_exit_ctl", 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
